// File: rtl/reg_hazard_scoreboard.sv
// Destination shadow pipeline, RAW-hazard stall and WB write-port control.
// Optional SCOREBOARD_FORWARD_EN: EX/MEM->ID forwarding, stall only on load-use.
module reg_hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [2:0]       i_id_rs,
  input  logic             i_id_rs_used,
  input  logic [2:0]       i_id_rt,
  input  logic             i_id_rt_used,
  input  logic [2:0]       i_id_rd,
  input  logic             i_id_we,
  input  logic             i_id_is_load,
  input  logic             i_flush,
  input  logic             i_stat_clr,
  output logic             o_stall,
  output logic [7:0]       o_busy_mask,
  output logic             o_wb_we,
  output logic [2:0]       o_wb_rd,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_count
);

  logic [DEPTH:1]   r_v;
  logic [DEPTH:1]   r_we;
  logic [DEPTH:1]   r_ld;
  logic [2:0]       r_rd [1:DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic [DEPTH:1]   w_ma;
  logic [DEPTH:1]   w_mb;
  logic [7:0]       w_busy;
  logic             w_raw;
  logic             w_stall;
  logic             w_accept;
  logic [1:0]       w_fa;
  logic [1:0]       w_fb;
  logic             w_unused;

  always_comb begin
    w_ma = '0;
    w_mb = '0;
    w_busy = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_ma[k] = i_id_rs_used & r_v[k] & r_we[k]
              & (r_rd[k] == i_id_rs);
      w_mb[k] = i_id_rt_used & r_v[k] & r_we[k]
              & (r_rd[k] == i_id_rt);
      if (r_v[k] & r_we[k])
        w_busy[r_rd[k]] = 1'b1;
    end
  end

`ifdef SCOREBOARD_FORWARD_EN
  // EX and MEM results are forwarded; only a load in EX,
  // or a writer beyond MEM but before WB, must wait.
  always_comb begin
    w_raw = r_ld[1] & (w_ma[1] | w_mb[1]);
    for (int k = 3; k < DEPTH; k++)
      w_raw = w_raw | w_ma[k] | w_mb[k];
    w_fa = 2'd0;
    w_fb = 2'd0;
    if (w_ma[1])
      w_fa = 2'd1;
    else if ((DEPTH > 2) && w_ma[2])
      w_fa = 2'd2;
    if (w_mb[1])
      w_fb = 2'd1;
    else if ((DEPTH > 2) && w_mb[2])
      w_fb = 2'd2;
  end
`else
  // WB stage excluded: the register file is write-through.
  always_comb begin
    w_raw = |(w_ma[DEPTH-1:1] | w_mb[DEPTH-1:1]);
    w_fa = 2'd0;
    w_fb = 2'd0;
  end
`endif

  assign w_stall  = i_id_valid & w_raw & ~i_flush;
  assign w_accept = i_id_valid & ~w_stall & ~i_flush;
  assign w_unused = ^{r_ld, w_ma[DEPTH], w_mb[DEPTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_we <= '0;
      r_ld <= '0;
      for (int k = 1; k <= DEPTH; k++)
        r_rd[k] <= 3'd0;
    end else begin
      r_v  <= {r_v[DEPTH-1:1], w_accept};
      r_we <= {r_we[DEPTH-1:1], w_accept & i_id_we};
      r_ld <= {r_ld[DEPTH-1:1], w_accept & i_id_is_load};
      r_rd[1] <= w_accept ? i_id_rd : 3'd0;
      for (int k = 2; k <= DEPTH; k++)
        r_rd[k] <= r_rd[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_stat_clr)
      r_cnt <= '0;
    else if (w_stall && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_stall       = w_stall;
  assign o_busy_mask   = w_busy;
  assign o_wb_we       = r_v[DEPTH] & r_we[DEPTH];
  assign o_wb_rd       = r_rd[DEPTH];
  assign o_fwd_a_sel   = w_fa;
  assign o_fwd_b_sel   = w_fb;
  assign o_stall_count = r_cnt;

endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Tracks in-flight register writes from decode to writeback and generates the decode-stage RAW-hazard stall for the pipelined core.
- Consumes the rd/we_reg pair produced by the destination decoder for the instruction in decode.
- Shifts that pair down a DEPTH-stage shadow pipeline and drives the register-file write-port controls from the last stage.
- Also keeps a saturating stall performance counter.

Parameters:
- DEPTH, 3, number of stages after decode; stage 1 = EX, stage DEPTH = WB. Legal range 2..6.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  valid instruction in decode
- id_rs  input  3  first source register
- id_rs_used  input  1  id_rs is read
- id_rt  input  3  second source register
- id_rt_used  input  1  id_rt is read
- id_rd  input  3  destination register from destination decoder
- id_we  input  1  we_reg from destination decoder
- id_is_load  input  1  instruction is LD
- flush  input  1  branch/jump resolved in EX; kill the instruction in decode
- stat_clr  input  1  synchronous clear of stall_count
- stall  output  1  hold PC/IF/ID and insert bubble (combinational)
- busy_mask  output  8  bit r=1 if any valid stage 1..DEPTH writes r (combinational)
- wb_we  output  1  register-file write enable (registered, stage DEPTH)
- wb_rd  output  3  register-file write address (registered, stage DEPTH)
- fwd_a_sel  output  2  forward select for rs: 0 regfile, 1 EX, 2 MEM
- fwd_b_sel  output  2  forward select for rt, same encoding
- stall_count  output  CNT_W  number of stalled cycles, saturating

Behaviour:
- Each stage k holds the entry {v, we, rd, ld}.
- Reset (async, rst_n=0): all stage entries 0, wb_we=0, wb_rd=0, stall_count=0. stall, busy_mask and fwd_* therefore read 0.
- Every clock, stage k+1 <= stage k. wb_we = v&we of stage DEPTH; wb_rd = rd of stage DEPTH.
- Stage 1 load:
  - If id_valid & !stall & !flush: stage 1 <= {1, id_we, id_rd, id_is_load}.
  - Otherwise stage 1 <= bubble (all 0).
- Match(s, k): stage k has v & we & rd==s.
- Entries with we=0 (ST, STU, branches, J, JR, NOP, HALT) never match, whatever their rd field holds.
- JAL/JALR entries arrive with rd=7 and match readers of R7 normally.
- Stage DEPTH never causes a hazard: the register file is write-through, so a same-cycle read returns the written value.
- Hazard without the feature:
  - raw = id_valid & ((id_rs_used & Match(id_rs, k)) | (id_rt_used & Match(id_rt, k))) for any k in 1..DEPTH-1.
  - stall = raw & !flush.
- flush has priority over stall: the decode instruction is discarded, stage 1 gets a bubble, and older stages continue shifting.
- stall_count:
  - stat_clr=1 -> 0.
  - Else if stall=1 and count != all-ones -> count+1.
  - At all-ones it holds (no wrap).
  - stat_clr takes priority over increment.
- Latency: an instruction accepted in decode at cycle t presents wb_we/wb_rd during cycle t+DEPTH.
- Multiple matching stages: the youngest (lowest k) determines fwd select.

Optional Feature:
- Macro: SCOREBOARD_FORWARD_EN.
- Defined:
  - EX->ID and MEM->ID forwarding is in use.
  - fwd_a_sel = 1 if Match(id_rs, 1) & id_rs_used, else 2 if Match(id_rs, 2) & id_rs_used (and 2 < DEPTH), else 0. fwd_b_sel is the same using id_rt.
  - Stall is raised only on load-use: a source matches stage 1 with ld=1.
  - Stall is also raised on a match in stages 3..DEPTH-1 when DEPTH > 3.
  - Stall is still masked by flush.
- Undefined: fwd_a_sel and fwd_b_sel are tied to 2'b00, and the hazard rule above (no forwarding) applies.

Test Plan:
- rst_n dropped asynchronously mid-stream with 3 entries in flight -> wb_we=0, busy_mask=8'h00, stall=0, stall_count=0 immediately, before any clock edge. After release, the first accepted instruction reaches wb 3 cycles later.
- No macro, DEPTH=3: ADD r1 then ADD r2 reading r1 -> stall=1 for 2 cycles, stall_count=2. The reader's wb_we/wb_rd=2 appears 3 cycles after it is accepted.
- SCOREBOARD_FORWARD_EN: ADD r1 then SUB reading r1 -> stall=0, fwd_a_sel=1. With one NOP between them -> fwd_a_sel=2. With two NOPs between them -> fwd_a_sel=0.
- SCOREBOARD_FORWARD_EN: LD r3 then ADD reading r3 as rt -> stall=1 for 1 cycle, then fwd_b_sel=2 and stall=0.
- ST with rd field=1 and we=0, followed by reader of r1 -> no stall. JAL (rd=7, we=1) followed by JR reading r7 -> stall (no macro) and busy_mask=8'h80.
- Hazard present and flush=1 in the same cycle -> stall=0, stage 1 bubble, stall_count unchanged. Counter preloaded to 16'hFFFF with stall held -> stays 16'hFFFF. stat_clr=1 together with stall -> 0.
